// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART transmit path.
// The optional parity bit is selected by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign bit_tick = enable && (count_q == LAST);

  // Next count: clear wins, otherwise wrap to zero at the end of each bit period.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = bit_tick ? '0 : count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences one UART frame per request, driving the external
// shift register's load/shift strobes and muxing start/data/parity/stop onto tx.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       data_bit,
  output logic       load_data,
  output logic       shift,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
  import uart_pkg::*;

  uart_tx_state_t state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           bit_tick;
  logic           baud_clear;
  logic           baud_enable;

  assign baud_clear  = (state_q == ST_IDLE);
  assign baud_enable = (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .enable   (baud_enable),
    .bit_tick (bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Capture even parity of the byte at the same edge the shift register loads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && tx_start) begin
      parity_q <= ^tx_data;
    end
  end
`else
  logic unused_tx_data;
  assign unused_tx_data = ^tx_data;
`endif

  // State and bit index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic, shift register strobes and the serial line mux.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_data = 1'b0;
    shift     = 1'b0;
    tx_done   = 1'b0;
    tx        = UART_STOP_BIT;
    case (state_q)
      ST_IDLE: begin
        tx        = UART_STOP_BIT;
        load_data = tx_start;
        if (tx_start) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx = UART_START_BIT;
        if (bit_tick) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        tx = data_bit;
        if (bit_tick) begin
          if (idx_q != 3'd7) begin
            shift = 1'b1;
            idx_d = idx_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = parity_q;
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx = UART_STOP_BIT;
        if (bit_tick) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with CLKS_PER_BIT=4 and a
// behavioural parallel-in/serial-out shift register on data_bit.
// Honours UART_TX_PARITY_EN for the frame length and parity bit.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 10 * CPB;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       txStart;
  logic [7:0] txData;
  logic       dataBit;
  logic       loadData;
  logic       shiftStrobe;
  logic       txLine;
  logic       busy;
  logic       txDone;
  logic [7:0] shiftReg;

  logic txLog    [0:127];
  logic busyLog  [0:127];
  logic doneLog  [0:127];
  logic loadLog  [0:127];
  logic shiftLog [0:127];

  int total;
  int bad;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (txStart),
    .tx_data   (txData),
    .data_bit  (dataBit),
    .load_data (loadData),
    .shift     (shiftStrobe),
    .tx        (txLine),
    .busy      (busy),
    .tx_done   (txDone)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register model feeding the controller, LSB out first.
  always @(posedge clk) begin
    if (rst) begin
      shiftReg <= 8'h00;
    end else if (loadData) begin
      shiftReg <= txData;
    end else if (shiftStrobe) begin
      shiftReg <= {1'b0, shiftReg[7:1]};
    end
  end
  assign dataBit = shiftReg[0];

  // Expected serial level at cycle c (0-based from START entry) for byte d.
  function automatic logic exp_tx(input logic [7:0] d, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PAR && (k == 9)) return ^d;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one request at index 0 and logs n cycles of outputs, each sampled
  // 1 ns after the falling edge that set that cycle's inputs.
  task automatic applyStimulus(input int n, input logic [7:0] d1, input logic [7:0] d2,
                               input bit hold, input int pulseAt, input int rstAt);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      txStart = (i == 0) || hold || (i == pulseAt);
      txData  = (i == 0) ? d1 : d2;
      rst     = (i == rstAt);
      #1;
      txLog[i]    = txLine;
      busyLog[i]  = busy;
      doneLog[i]  = txDone;
      loadLog[i]  = loadData;
      shiftLog[i] = shiftStrobe;
    end
    txStart = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    txStart = 1'b0;
    txData  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      #1;
      total++; if (txLine !== 1'b1) begin bad++; $display("[TB] FAIL reset.tx got=%b want=1", txLine); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset.busy got=%b want=0", busy); end
      total++; if (txDone !== 1'b0) begin bad++; $display("[TB] FAIL reset.tx_done got=%b want=0", txDone); end
      total++; if (loadData !== 1'b0) begin bad++; $display("[TB] FAIL reset.load_data got=%b want=0", loadData); end
      total++; if (shiftStrobe !== 1'b0) begin bad++; $display("[TB] FAIL reset.shift got=%b want=0", shiftStrobe); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_frame;
    logic [10:0] hand;
    logic expTx, expBusy, expDone, expLoad, expShift;
    int c, k, shifts;
`ifdef UART_TX_PARITY_EN
    hand = 11'b111_0110_0110;
`else
    hand = 11'b011_0110_0110;
`endif
    shifts = 0;
    idle(1);
    applyStimulus(FRAME + 2, 8'hB3, 8'hB3, 1'b0, -1, -1);
    for (int i = 0; i <= FRAME + 1; i++) begin
      c = i - 1;
      k = (c >= 0) ? c / CPB : 0;
      expTx    = (i >= 1 && i <= FRAME) ? hand[k] : 1'b1;
      expBusy  = (i >= 1 && i <= FRAME);
      expDone  = (i == FRAME);
      expLoad  = (i == 0);
      expShift = (i >= 1) && (c % CPB == CPB - 1) && (k >= 1) && (k <= 7);
      if (shiftLog[i] === 1'b1) shifts++;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL single.tx[%0d] got=%b want=%b", i, txLog[i], expTx); end
      total++; if (busyLog[i] !== expBusy) begin bad++; $display("[TB] FAIL single.busy[%0d] got=%b want=%b", i, busyLog[i], expBusy); end
      total++; if (doneLog[i] !== expDone) begin bad++; $display("[TB] FAIL single.tx_done[%0d] got=%b want=%b", i, doneLog[i], expDone); end
      total++; if (loadLog[i] !== expLoad) begin bad++; $display("[TB] FAIL single.load_data[%0d] got=%b want=%b", i, loadLog[i], expLoad); end
      total++; if (shiftLog[i] !== expShift) begin bad++; $display("[TB] FAIL single.shift[%0d] got=%b want=%b", i, shiftLog[i], expShift); end
      total++; if ((loadLog[i] & shiftLog[i]) !== 1'b0) begin bad++; $display("[TB] FAIL single.strobe_excl[%0d] got=1 want=0", i); end
    end
    total++; if (shifts != 7) begin bad++; $display("[TB] FAIL single.shift_count got=%0d want=7", shifts); end
  endtask

  task automatic test_ignored_request;
    logic expTx;
    idle(2);
    applyStimulus(FRAME + 2, 8'h3C, 8'h3C, 1'b0, 1 + 2 * CPB + 2, -1);
    for (int i = 0; i <= FRAME + 1; i++) begin
      expTx = (i >= 1 && i <= FRAME) ? exp_tx(8'h3C, i - 1) : 1'b1;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL ignored.tx[%0d] got=%b want=%b", i, txLog[i], expTx); end
      total++; if (loadLog[i] !== (i == 0)) begin bad++; $display("[TB] FAIL ignored.load_data[%0d] got=%b want=%b", i, loadLog[i], (i == 0)); end
      total++; if (doneLog[i] !== (i == FRAME)) begin bad++; $display("[TB] FAIL ignored.tx_done[%0d] got=%b want=%b", i, doneLog[i], (i == FRAME)); end
    end
  endtask

  task automatic test_back_to_back;
    logic expTx, expLoad, expBusy;
    int j;
    idle(2);
    applyStimulus(2 * FRAME + 2, 8'h00, 8'hFF, 1'b1, -1, -1);
    for (int i = 0; i <= 2 * FRAME + 1; i++) begin
      if (i <= FRAME) begin
        expTx   = (i >= 1) ? exp_tx(8'h00, i - 1) : 1'b1;
        expLoad = (i == 0);
        expBusy = (i >= 1);
      end else begin
        j       = i - (FRAME + 1);
        expTx   = (j >= 1) ? exp_tx(8'hFF, j - 1) : 1'b1;
        expLoad = (j == 0);
        expBusy = (j >= 1);
      end
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL b2b.tx[%0d] got=%b want=%b", i, txLog[i], expTx); end
      total++; if (loadLog[i] !== expLoad) begin bad++; $display("[TB] FAIL b2b.load_data[%0d] got=%b want=%b", i, loadLog[i], expLoad); end
      total++; if (busyLog[i] !== expBusy) begin bad++; $display("[TB] FAIL b2b.busy[%0d] got=%b want=%b", i, busyLog[i], expBusy); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic expTx;
    int rstAt;
    rstAt = 1 + 4 * CPB + 1;
    idle(3);
    applyStimulus(30, 8'hA5, 8'hA5, 1'b0, -1, rstAt);
    for (int i = rstAt + 1; i < 30; i++) begin
      total++; if (txLog[i] !== 1'b1) begin bad++; $display("[TB] FAIL midrst.tx[%0d] got=%b want=1", i, txLog[i]); end
      total++; if (busyLog[i] !== 1'b0) begin bad++; $display("[TB] FAIL midrst.busy[%0d] got=%b want=0", i, busyLog[i]); end
      total++; if (doneLog[i] !== 1'b0) begin bad++; $display("[TB] FAIL midrst.tx_done[%0d] got=%b want=0", i, doneLog[i]); end
    end
    idle(2);
    applyStimulus(FRAME + 2, 8'h5A, 8'h5A, 1'b0, -1, -1);
    for (int i = 0; i <= FRAME + 1; i++) begin
      expTx = (i >= 1 && i <= FRAME) ? exp_tx(8'h5A, i - 1) : 1'b1;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL midrst.next_tx[%0d] got=%b want=%b", i, txLog[i], expTx); end
      total++; if (doneLog[i] !== (i == FRAME)) begin bad++; $display("[TB] FAIL midrst.next_done[%0d] got=%b want=%b", i, doneLog[i], (i == FRAME)); end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    txStart = 1'b0;
    txData  = 8'h00;
    $display("[TB] starting uart_tx_ctrl bench, frame=%0d cycles", FRAME);
    test_reset;
    test_single_frame;
    test_ignored_request;
    test_back_to_back;
    test_reset_mid_frame;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
